ochiba_rv32im_muldiv: RTL
=========================

OCHIBA_RV32IM_MULDIV -- requirements
Module: ochiba_rv32im_muldiv

Interface
REQ-001 SHALL have parameter: XLEN, default 32, operand/result width.
REQ-002 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  issue request from Ex stage, qualified only in IDLE.
REQ-005 SHALL have port: funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have port: rs1  input  XLEN  operand A (dividend / multiplicand).
REQ-007 SHALL have port: rs2  input  XLEN  operand B (divisor / multiplier).
REQ-008 SHALL have port: flush  input  1  branch redirect; aborts any operation.
REQ-009 SHALL have port: Exnow  output  1  busy; to pipeline controller stall/clear inputs.
REQ-010 SHALL have port: done  output  1  one-cycle pulse, result valid.
REQ-011 SHALL have port: result  output  XLEN  operation result, held until next start.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE.
REQ-013 SHALL, in IDLE with start=1 and flush=0, latch funct3, absolute-value operands and result-sign flags, clear 5-bit counter, enter CALC.
REQ-014 SHALL drive Exnow combinationally high in the IDLE cycle accepting start and in every CALC cycle; low in IDLE (no start) and DONE.
REQ-015 SHALL iterate exactly 32 CALC cycles: MUL* radix-2 shift-add into a 64-bit accumulator; DIV*/REM* restoring shift-subtract, one quotient bit per cycle.
REQ-016 SHALL, for start at cycle T, assert done at T+33 (DONE state) with result valid; return to IDLE at T+34.
REQ-017 SHALL select MUL = product[31:0], MULH/MULHSU/MULHU = product[63:32], with signed/unsigned operand treatment per RV32M.
REQ-018 SHALL negate the unsigned magnitude on DONE entry when sign flag set: quotient sign = sign(rs1) XOR sign(rs2); remainder sign = sign(rs1).
REQ-019 SHALL, for divide by zero, skip CALC and enter DONE at T+1: DIV/DIVU = 0xFFFFFFFF, REM/REMU = rs1.
REQ-020 SHALL, for DIV/REM with rs1=0x80000000, rs2=0xFFFFFFFF, skip CALC, enter DONE at T+1: DIV = 0x80000000, REM = 0.
REQ-021 SHALL ignore start in CALC and DONE.
REQ-022 SHALL, on flush in any state, return to IDLE next edge, suppress done, leave result unchanged; flush beats start in the same cycle.
REQ-023 SHALL never assert Exnow and done in the same cycle.

Reset
REQ-024 SHALL, on reset low, asynchronously force state IDLE, counter 0, accumulators 0, result 0, done 0, Exnow 0.
REQ-025 SHALL abort any in-flight operation on reset with no done pulse after release.
REQ-026 SHALL not accept start until the first rising edge after reset deasserts.

Structure
REQ-027 SHALL take funct3 encodings, FSM state typedef and XLEN from shared package ochiba_rv32im_pkg.
REQ-028 SHALL be a single module with no sub-modules; the 64-bit add/subtract datapath is inline.

Verification
REQ-029 SHALL cover MUL rs1=7, rs2=-3: start at T -> Exnow high T..T+32, done at T+33, result 0xFFFFFFEB.
REQ-030 SHALL cover MULHU rs1=rs2=0xFFFFFFFF -> result 0xFFFFFFFE; MULH same operands -> 0x00000000.
REQ-031 SHALL cover DIV rs1=-7, rs2=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14.
REQ-032 SHALL cover DIVU rs1=5, rs2=0 -> done at T+1, 0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> done at T+1, 0x80000000.
REQ-033 SHALL cover flush at T+10 of a DIV -> IDLE at T+11, Exnow low at T+11, no done, result unchanged; start+flush same cycle -> no operation.
REQ-034 SHALL cover reset low at T+5 of a MUL -> outputs zero immediately; after release, a new MUL 3*4 -> 12 at its T+33.

Source files
------------

// File: rtl/ochiba_rv32im_pkg.sv
// Shared definitions for the RV32M multiply/divide unit:
// operand width, funct3 op encodings and FSM states.
package ochiba_rv32im_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } md_state_e;

    function automatic logic rs1_signed(input md_op_e op);
        return op inside {F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
    endfunction

    function automatic logic rs2_signed(input md_op_e op);
        return op inside {F3_MUL, F3_MULH, F3_DIV, F3_REM};
    endfunction

endpackage

// File: rtl/ochiba_rv32im_muldiv.sv
// Iterative RV32M multiply/divide: 32-cycle shift-add / restoring
// divide on operand magnitudes, sign fixed up on the last step.
module ochiba_rv32im_muldiv
    import ochiba_rv32im_pkg::*;
#(
    parameter int XLEN = ochiba_rv32im_pkg::XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            Exnow,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam int DW = 2 * XLEN;
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    md_state_e       state, state_nxt;
    md_op_e          op_q, op_in;
    logic [CW-1:0]   cnt;
    logic [DW-1:0]   acc, acc_nxt;
    logic [XLEN-1:0] areg, breg, result_q;
    logic            neg_q;

    logic            s1, s2, neg_in;
    logic [XLEN-1:0] a_abs, b_abs;
    logic            div0, ovf, accept;

    logic [XLEN:0]   top;
    logic [XLEN-1:0] sub;
    logic            ge;
    logic [DW-1:0]   prod;
    logic [XLEN-1:0] quo, rem, fin;

    assign op_in = md_op_e'(funct3);
    assign s1    = rs1_signed(op_in) & rs1[XLEN-1];
    assign s2    = rs2_signed(op_in) & rs2[XLEN-1];
    assign a_abs = s1 ? -rs1 : rs1;
    assign b_abs = s2 ? -rs2 : rs2;

    // remainder keeps the dividend sign; everything else is the xor
    assign neg_in = (op_in == F3_REM || op_in == F3_REMU) ? s1 : (s1 ^ s2);

    assign div0 = op_in[2] && (rs2 == '0);
    assign ovf  = (op_in == F3_DIV || op_in == F3_REM)
               && (rs1 == {1'b1, {(XLEN-1){1'b0}}})
               && (rs2 == '1);

    assign accept = reset && (state == S_IDLE) && start && !flush;

    always_comb begin
        top     = acc[DW-1:XLEN-1];
        ge      = top >= {1'b0, breg};
        sub     = top[XLEN-1:0] - breg;
        acc_nxt = acc;
        if (op_q[2]) begin
            if (ge)
                acc_nxt = {sub, acc[XLEN-2:0], 1'b1};
            else
                acc_nxt = {acc[DW-2:0], 1'b0};
        end else begin
            acc_nxt = {acc[DW-2:0], 1'b0}
                    + (breg[XLEN-1] ? {{XLEN{1'b0}}, areg} : {DW{1'b0}});
        end
    end

    always_comb begin
        prod = neg_q ? -acc_nxt : acc_nxt;
        quo  = acc_nxt[XLEN-1:0];
        rem  = acc_nxt[DW-1:XLEN];
        fin  = '0;
        case (op_q)
            F3_MUL:                         fin = prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:   fin = prod[DW-1:XLEN];
            F3_DIV, F3_DIVU:                fin = neg_q ? -quo : quo;
            F3_REM, F3_REMU:                fin = neg_q ? -rem : rem;
            default:                        fin = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        Exnow     = 1'b0;
        done      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    Exnow     = 1'b1;
                    state_nxt = (div0 || ovf) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                Exnow = reset;
                if (cnt == LAST)
                    state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = reset && !flush;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (flush)
            state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            op_q     <= F3_MUL;
            cnt      <= '0;
            acc      <= '0;
            areg     <= '0;
            breg     <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q  <= op_in;
                neg_q <= neg_in;
                cnt   <= '0;
                areg  <= a_abs;
                breg  <= b_abs;
                acc   <= op_in[2] ? {{XLEN{1'b0}}, a_abs} : {DW{1'b0}};
                if (div0)
                    result_q <= op_in[1] ? rs1 : '1;
                else if (ovf)
                    result_q <= op_in[1] ? '0 : rs1;
            end else if (state == S_CALC && !flush) begin
                acc <= acc_nxt;
                cnt <= cnt + 1'b1;
                if (!op_q[2])
                    breg <= breg << 1;
                if (cnt == LAST)
                    result_q <= fin;
            end
        end
    end

    assign result = result_q;

endmodule
